uart_rx: RTL

Asynchronous serial receiver for the UART: 8 data bits, LSB first, no parity, one stop bit (8N1). It synchronises the raw `rx_in` line, finds each start bit, times its own mid-bit sampling and delivers each received byte with a one-cycle strobe. It is the receive-side counterpart of the transmit path that the `div` baud tick drives. The RX path keeps its own bit counter, restarted on every start edge, so sampling stays centred on each bit.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync2.sv | 35 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: frame data width and the receive state encoding.
// The transmit side is expected to import this package as well.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk_in    - destination clock
//   rst_n_in  - asynchronous active-low reset; both flops load RST_VAL
//   d         - asynchronous input
//   q         - synchronised output (two clk_in cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync2

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver. Finds the start bit, times its own
// mid-bit sampling points from that edge and delivers each byte with a
// one-cycle strobe.
// Ports:
//   clk_in        - system clock, rising edge
//   rst_n_in      - asynchronous active-low reset
//   rx_in         - serial line (asynchronous, idles high)
//   data_out      - last good byte, held until the next good byte
//   valid_out     - one-cycle pulse when data_out updates
//   frame_err_out - one-cycle pulse when the stop bit samples low
//   busy_out      - high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 busy_out
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE     = IW'(1);

    // Below four cycles per bit the half-bit reload collapses to zero.
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    logic                 rxs_s;
    rx_state_t            state_r,  state_nxt_s;
    logic [CW-1:0]        cnt_r,    cnt_nxt_s;
    logic [IW-1:0]        idx_r,    idx_nxt_s;
    logic [DATA_BITS-1:0] sh_r,     sh_nxt_s;
    logic [DATA_BITS-1:0] data_r,   data_nxt_s;
    logic                 valid_r,  valid_nxt_s;
    logic                 ferr_r,   ferr_nxt_s;
    logic                 busy_r;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d        (rx_in),
        .q        (rxs_s)
    );

    // Next-state, counter, shift register and strobe logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        sh_nxt_s    = sh_r;
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
        ferr_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxs_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = HALF_RELOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                // Re-check the line at the start-bit midpoint to reject glitches.
                if (cnt_r == CNT_ZERO) begin
                    if (!rxs_s) begin
                        state_nxt_s = DATA;
                        cnt_nxt_s   = FULL_RELOAD;
                        idx_nxt_s   = {IW{1'b0}};
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == CNT_ZERO) begin
                    // LSB arrives first, so shift in from the MSB end.
                    sh_nxt_s  = {rxs_s, sh_r[DATA_BITS-1:1]};
                    cnt_nxt_s = FULL_RELOAD;
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = STOP;
                    end else begin
                        idx_nxt_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == CNT_ZERO) begin
                    if (rxs_s) begin
                        data_nxt_s  = sh_r;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        ferr_nxt_s  = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            BREAK: begin
                // A held-low line must not look like a stream of start bits.
                if (rxs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; busy follows the next state so it
    // drops in the same cycle as the strobe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= {IW{1'b0}};
            sh_r    <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            sh_r    <= sh_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            ferr_r  <= ferr_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign data_out      = data_r;
    assign valid_out     = valid_r;
    assign frame_err_out = ferr_r;
    assign busy_out      = busy_r;

endmodule : uart_rx
